// File: rtl/cpu_pkg.sv
// Shared constants and types for the per-thread fetch scheduler.
package cpu_pkg;

   localparam int          NTHREADS = 4;
   localparam int          THREAD_W = 2;
   localparam int          PC_STEP  = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   // The fetch FSM either arbitrates (IDLE) or waits for a fetch ack (REQ).
   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } fetch_state_e;

   // Contents of the single-entry instruction buffer handed to decode.
   typedef struct packed {
      logic [31:0]         data;
      logic [31:0]         pc;
      logic [THREAD_W-1:0] thread;
   } ir_entry_t;

   // Sequential PC advance; wraps silently at 2^32.
   function automatic logic [31:0] next_pc(input logic [31:0] pc, input int step);
      return pc + 32'(step);
   endfunction

endpackage

// File: rtl/fetch_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly
// after the last granted index, wrapping from NREQ-1 back to 0.
module rr_arbiter
   import cpu_pkg::*;
#(
   parameter int NREQ = NTHREADS
) (
   input  logic [NREQ-1:0]     req,
   input  logic [THREAD_W-1:0] last,
   output logic                grant_valid,
   output logic [THREAD_W-1:0] grant
);

   // Scan candidates last+1 .. last+NREQ and keep the first one requesting.
   always_comb begin
      logic [THREAD_W-1:0] cand;
      // NOTE: every output gets a value before any branch so no latch is inferred.
      grant_valid = 1'b0;
      grant       = '0;
      cand        = '0;
      for (int off = 1; off <= NREQ; off++) begin
         cand = THREAD_W'((int'(last) + off) % NREQ);
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant       = cand;
         end
      end
   end

endmodule

// File: rtl/fetch_sched.sv
// Per-thread PC file and fetch-request scheduler. Picks the next runnable
// thread round-robin, issues one fetch at a time, captures the returned word
// into a single-entry buffer for decode, and applies branch redirects
// (including squashing a fetch already in flight for the redirected thread).
module fetch_sched #(
   parameter int          NTHREADS = cpu_pkg::NTHREADS,
   parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
   parameter int          PC_STEP  = cpu_pkg::PC_STEP
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NTHREADS-1:0]          thread_en,
   output logic                         f_enable,
   output logic [31:0]                  f_addr,
   output logic [cpu_pkg::THREAD_W-1:0] f_thread,
   input  logic                         f_ack,
   input  logic [31:0]                  f_data,
   output logic                         ir_valid,
   output logic [31:0]                  ir_data,
   output logic [31:0]                  ir_pc,
   output logic [cpu_pkg::THREAD_W-1:0] ir_thread,
   input  logic                         ir_ready,
   input  logic                         br_valid,
   input  logic [cpu_pkg::THREAD_W-1:0] br_thread,
   input  logic [31:0]                  br_target
);

   import cpu_pkg::THREAD_W;
   import cpu_pkg::fetch_state_e;
   import cpu_pkg::IDLE;
   import cpu_pkg::REQ;
   import cpu_pkg::ir_entry_t;
   import cpu_pkg::next_pc;

   fetch_state_e        state, next_state;
   logic [31:0]         pc [NTHREADS];
   logic [THREAD_W-1:0] last_grant;
   logic                squash;
   ir_entry_t           ir_entry;

   logic                arb_valid;
   logic [THREAD_W-1:0] arb_idx;

   logic                buf_free;
   logic                issue;
   logic                ack_done;
   logic                deliver;
   logic [31:0]         issue_addr;

   rr_arbiter #(
      .NREQ (NTHREADS)
   ) u_arb (
      .req         (thread_en),
      .last        (last_grant),
      .grant_valid (arb_valid),
      .grant       (arb_idx)
   );

   assign f_enable  = (state == REQ);
   assign ir_data   = ir_entry.data;
   assign ir_pc     = ir_entry.pc;
   assign ir_thread = ir_entry.thread;

   // Next-state and per-cycle control: when to issue, when an ack ends a
   // request, and whether the acked word is kept or dropped.
   always_comb begin
      next_state = state;
      issue      = 1'b0;
      ack_done   = 1'b0;
      deliver    = 1'b0;
      // Decode consuming this cycle frees the buffer for this arbitration.
      buf_free   = !ir_valid || ir_ready;
      // A redirect landing on the thread being granted supplies the address
      // directly, so the new request never fetches the stale PC.
      issue_addr = (br_valid && br_thread == arb_idx) ? br_target : pc[arb_idx];
      case (state)
         IDLE: begin
            if (buf_free && arb_valid) begin
               issue      = 1'b1;
               next_state = REQ;
            end
         end
         REQ: begin
            if (f_ack) begin
               ack_done   = 1'b1;
               next_state = IDLE;
               // Drop the word if this thread was redirected earlier in the
               // request or is being redirected on the ack cycle itself.
               deliver    = !squash && !(br_valid && br_thread == f_thread);
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples pre-edge values regardless of statement order.
         state <= next_state;
      end
   end

   // Outstanding request registers and round-robin pointer, loaded on issue
   // and held stable for the whole request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_addr     <= '0;
         f_thread   <= '0;
         last_grant <= THREAD_W'(NTHREADS - 1);
      end else if (issue) begin
         f_addr     <= issue_addr;
         f_thread   <= arb_idx;
         last_grant <= arb_idx;
      end
   end

   // Squash flag: set when the in-flight request's thread is redirected,
   // cleared by the ack that ends that request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         squash <= 1'b0;
      end else if (ack_done) begin
         squash <= 1'b0;
      end else if (state == REQ && br_valid && br_thread == f_thread) begin
         squash <= 1'b1;
      end
   end

   // Instruction buffer: load on a kept ack; empty on consumption or when
   // its thread is redirected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_valid <= 1'b0;
         ir_entry <= '0;
      end else if (deliver) begin
         ir_valid        <= 1'b1;
         ir_entry.data   <= f_data;
         ir_entry.pc     <= f_addr;
         ir_entry.thread <= f_thread;
      end else if (ir_valid && br_valid && br_thread == ir_entry.thread) begin
         ir_valid <= 1'b0;
      end else if (ir_valid && ir_ready) begin
         ir_valid <= 1'b0;
      end
   end

   // PC file: a redirect overrides the post-fetch increment for its thread.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the PC array is reset because every thread must start at
         // RESET_PC; it is small enough to live in flops rather than RAM.
         for (int t = 0; t < NTHREADS; t++) begin
            pc[t] <= RESET_PC;
         end
      end else begin
         for (int t = 0; t < NTHREADS; t++) begin
            if (br_valid && br_thread == THREAD_W'(t)) begin
               pc[t] <= br_target;
            end else if (deliver && f_thread == THREAD_W'(t)) begin
               pc[t] <= next_pc(f_addr, PC_STEP);
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_sched.sv
// Scoreboard bench for fetch_sched: the stimulus thread pushes expected fetch
// requests and expected decoded words; a monitor pops and compares whenever
// the DUT presents a new request or decode consumes the buffer.
module tb_fetch_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  thread_en = '0;
   logic        f_enable;
   logic [31:0] f_addr;
   logic [1:0]  f_thread;
   logic        f_ack = 1'b0;
   logic [31:0] f_data = '0;
   logic        ir_valid;
   logic [31:0] ir_data;
   logic [31:0] ir_pc;
   logic [1:0]  ir_thread;
   logic        ir_ready = 1'b1;
   logic        br_valid = 1'b0;
   logic [1:0]  br_thread = '0;
   logic [31:0] br_target = '0;

   fetch_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .thread_en (thread_en),
      .f_enable  (f_enable),
      .f_addr    (f_addr),
      .f_thread  (f_thread),
      .f_ack     (f_ack),
      .f_data    (f_data),
      .ir_valid  (ir_valid),
      .ir_data   (ir_data),
      .ir_pc     (ir_pc),
      .ir_thread (ir_thread),
      .ir_ready  (ir_ready),
      .br_valid  (br_valid),
      .br_thread (br_thread),
      .br_target (br_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  thread;
      logic [31:0] addr;
   } req_t;

   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
      logic [1:0]  thread;
   } ir_t;

   req_t req_q[$];
   ir_t  ir_q[$];
   int   errors = 0;
   int   checks = 0;
   logic req_seen = 1'b0;
   req_t mon_req;
   ir_t  mon_ir;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_ir(input logic [31:0] d, input logic [31:0] a, input logic [1:0] t);
      ir_t e;
      e.data   = d;
      e.pc     = a;
      e.thread = t;
      ir_q.push_back(e);
   endtask

   // Queue the expected request, then wait (bounded) until it is presented.
   task automatic wait_req(input logic [1:0] t, input logic [31:0] a);
      req_t r;
      bit   got;
      r.thread = t;
      r.addr   = a;
      req_q.push_back(r);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (f_enable) got = 1'b1;
         else step();
      end
      if (!got) check("req_timeout", 32'(f_enable), 32'd1);
   endtask

   // Wait for the request and acknowledge it with data on the next edge.
   task automatic serve(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                        input bit keep);
      wait_req(t, a);
      if (keep) expect_ir(d, a, t);
      f_ack  = 1'b1;
      f_data = d;
      step();
      f_ack  = 1'b0;
      f_data = '0;
   endtask

   // Monitor: compare each newly presented request and each consumed word.
   always @(negedge clk) begin
      if (rst_n && f_enable && !req_seen) begin
         if (req_q.size() == 0) begin
            check("unexpected_req", 32'(f_enable), 32'd0);
         end else begin
            mon_req = req_q.pop_front();
            check("req_thread", 32'(f_thread), 32'(mon_req.thread));
            check("req_addr", f_addr, mon_req.addr);
         end
      end
      req_seen <= f_enable;
      if (rst_n && ir_valid && ir_ready) begin
         if (ir_q.size() == 0) begin
            check("unexpected_ir", 32'(ir_valid), 32'd0);
         end else begin
            mon_ir = ir_q.pop_front();
            check("ir_data", ir_data, mon_ir.data);
            check("ir_pc", ir_pc, mon_ir.pc);
            check("ir_thread", 32'(ir_thread), 32'(mon_ir.thread));
         end
      end
   end

   initial begin
      // Reset state.
      #1 rst_n = 1'b0;
      #2;
      check("rst_f_enable", 32'(f_enable), 32'd0);
      check("rst_f_addr", f_addr, 32'd0);
      check("rst_ir_valid", 32'(ir_valid), 32'd0);
      thread_en = 4'b1111;
      step();
      step();
      rst_n = 1'b1;

      // All threads enabled: round-robin 0,1,2,3,0.
      serve(2'd0, 32'h0000_0000, 32'hA000_0000, 1'b1);
      serve(2'd1, 32'h0000_0000, 32'hA000_0001, 1'b1);
      serve(2'd2, 32'h0000_0000, 32'hA000_0002, 1'b1);
      serve(2'd3, 32'h0000_0000, 32'hA000_0003, 1'b1);
      serve(2'd0, 32'h0000_0004, 32'hA000_0004, 1'b1);

      // Only threads 0 and 2 runnable; last grant was 0.
      thread_en = 4'b0101;
      serve(2'd2, 32'h0000_0004, 32'hB000_0002, 1'b1);
      serve(2'd0, 32'h0000_0008, 32'hB000_0000, 1'b1);
      serve(2'd2, 32'h0000_0008, 32'hB000_0012, 1'b1);

      // No runnable threads: no request.
      thread_en = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         step();
         check("idle_no_req", 32'(f_enable), 32'd0);
      end

      // Decode stalled: buffer holds, no new request.
      ir_ready  = 1'b0;
      thread_en = 4'b1111;
      serve(2'd3, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("hold_ir_valid", 32'(ir_valid), 32'd1);
         check("hold_ir_data", ir_data, 32'hDEAD_BEEF);
         check("hold_ir_pc", ir_pc, 32'h0000_0004);
         check("hold_no_req", 32'(f_enable), 32'd0);
      end
      ir_ready = 1'b1;
      serve(2'd0, 32'h0000_000C, 32'hC000_0000, 1'b1);

      // Redirect thread 1 while its fetch is outstanding: word dropped.
      wait_req(2'd1, 32'h0000_0004);
      thread_en = 4'b0010;
      br_valid  = 1'b1;
      br_thread = 2'd1;
      br_target = 32'h0000_0100;
      step();
      br_valid = 1'b0;
      f_ack    = 1'b1;
      f_data   = 32'hBAD0_0001;
      step();
      f_ack = 1'b0;
      check("squash_no_ir", 32'(ir_valid), 32'd0);
      ir_ready = 1'b0;
      serve(2'd1, 32'h0000_0100, 32'hD000_0100, 1'b0);
      check("buf_t1_valid", 32'(ir_valid), 32'd1);
      check("buf_t1_data", ir_data, 32'hD000_0100);
      check("buf_t1_pc", ir_pc, 32'h0000_0100);

      // Redirect of another thread leaves the buffered word alone.
      br_valid  = 1'b1;
      br_thread = 2'd3;
      br_target = 32'h0000_0300;
      step();
      br_valid = 1'b0;
      check("other_br_keeps_ir", 32'(ir_valid), 32'd1);

      // Redirect of the buffered word's thread empties the buffer.
      br_valid  = 1'b1;
      br_thread = 2'd1;
      br_target = 32'h0000_0200;
      step();
      br_valid = 1'b0;
      check("br_clears_ir", 32'(ir_valid), 32'd0);

      // Redirect and ack on the same cycle for the same thread.
      wait_req(2'd1, 32'h0000_0200);
      f_ack     = 1'b1;
      f_data    = 32'hBAD0_0002;
      br_valid  = 1'b1;
      br_thread = 2'd1;
      br_target = 32'h0000_0400;
      step();
      f_ack    = 1'b0;
      br_valid = 1'b0;
      check("br_ack_same_drop", 32'(ir_valid), 32'd0);
      check("br_ack_same_idle", 32'(f_enable), 32'd0);
      ir_ready = 1'b1;

      // Redirect of a different thread on the ack cycle does not disturb it.
      wait_req(2'd1, 32'h0000_0400);
      expect_ir(32'hE000_0400, 32'h0000_0400, 2'd1);
      f_ack     = 1'b1;
      f_data    = 32'hE000_0400;
      br_valid  = 1'b1;
      br_thread = 2'd2;
      br_target = 32'h0000_0500;
      step();
      f_ack    = 1'b0;
      br_valid = 1'b0;
      check("other_br_ack_pc", ir_pc, 32'h0000_0400);

      // Reset during an outstanding request; a late ack is ignored.
      thread_en = 4'b0100;
      wait_req(2'd2, 32'h0000_0500);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_f_enable", 32'(f_enable), 32'd0);
      check("mid_rst_f_addr", f_addr, 32'd0);
      check("mid_rst_f_thread", 32'(f_thread), 32'd0);
      check("mid_rst_ir_valid", 32'(ir_valid), 32'd0);
      check("mid_rst_ir_data", ir_data, 32'd0);
      check("mid_rst_ir_pc", ir_pc, 32'd0);
      thread_en = 4'b0000;
      step();
      f_ack  = 1'b1;
      f_data = 32'hBAD0_0003;
      rst_n  = 1'b1;
      step();
      f_ack = 1'b0;
      check("late_ack_no_ir", 32'(ir_valid), 32'd0);
      check("late_ack_idle", 32'(f_enable), 32'd0);

      // PCs restart at RESET_PC and thread 0 goes first.
      thread_en = 4'b0001;
      serve(2'd0, 32'h0000_0000, 32'hF000_0000, 1'b1);
      thread_en = 4'b0000;
      for (int i = 0; i < 4; i++) step();

      check("req_queue_drained", 32'(req_q.size()), 32'd0);
      check("ir_queue_drained", 32'(ir_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_sched.md
# fetch_sched

Per-thread program-counter and fetch-request scheduler sitting directly upstream of the CPU fetch stage. It holds one PC per hardware thread, picks the next runnable thread round-robin, drives a read request into fetch, and captures the returned instruction word into a single-entry buffer for decode. Branch redirects from execute update PCs and squash stale fetches.

## Interface
Parameters:
- NTHREADS, 4, number of hardware threads (THREAD_W = 2 fixed for 4)
- RESET_PC, 32'h0000_0000, PC loaded into every thread at reset
- PC_STEP, 4, PC increment per fetched word

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- thread_en  in  NTHREADS  runnable mask, bit t = thread t may fetch
- f_enable  out  1  fetch request to fetch stage (write_mode held 0 by this block)
- f_addr  out  32  fetch address
- f_thread  out  2  thread tag of request
- f_ack  in  1  fetch completed, f_data valid this cycle
- f_data  in  32  fetched instruction word
- ir_valid  out  1  instruction buffer holds a word
- ir_data  out  32  buffered instruction
- ir_pc  out  32  PC of buffered instruction
- ir_thread  out  2  thread of buffered instruction
- ir_ready  in  1  decode consumes buffer this cycle when ir_valid
- br_valid  in  1  redirect request
- br_thread  in  2  thread being redirected
- br_target  in  32  new PC

## Operation
- State machine: IDLE, REQ.
- IDLE: if buffer free (ir_valid=0, or ir_valid&ir_ready this cycle) and any thread_en bit set, choose next enabled thread strictly after last-issued (round-robin, wrap NTHREADS-1 -> 0), register f_thread, f_addr=pc[t], f_enable=1, go REQ. Otherwise stay IDLE, f_enable=0.
- REQ: f_enable, f_addr, f_thread held stable until f_ack. On f_ack: deassert f_enable; unless squashed, load ir_data=f_data, ir_pc=f_addr, ir_thread=f_thread, ir_valid=1, pc[t]=f_addr+PC_STEP (mod 2^32, wraps silently); go IDLE.
- Redirect (br_valid): pc[br_thread]=br_target same edge.
  - If REQ outstanding for br_thread: set squash flag; on its f_ack word dropped, ir_valid unchanged, pc not incremented. Squash clears on that ack.
  - If buffered ir_thread==br_thread and ir_valid: ir_valid cleared.
  - br_valid and f_ack same cycle, same thread: redirect wins, word dropped, pc=br_target.
  - Redirect for other threads never disturbs the outstanding request.
- Clearing a thread_en bit while that thread's request is outstanding does not abort it; the word is delivered normally.
- ir_valid&ir_ready with no reload: ir_valid=0 next cycle.

## Timing
- Reset (async assert): state IDLE, f_enable=0, f_addr=0, f_thread=0, ir_valid=0, ir_data=0, ir_pc=0, ir_thread=0, all pc=RESET_PC, squash=0, round-robin pointer = NTHREADS-1 (thread 0 first). Release synchronous to clk.
- First request: f_enable high the first edge after rst_n deasserted with thread_en!=0.
- f_ack at edge N -> ir_valid high after edge N; next f_enable earliest after edge N+1 (IDLE arbitration cycle). Peak rate one word per 2 cycles plus fetch latency.
- Consumption and new request may overlap: ir_ready in IDLE frees buffer for that cycle's arbitration.
- Reset mid-REQ: request dropped; late f_ack after reset ignored (state IDLE).

## Structure
- cpu_pkg: NTHREADS, THREAD_W, PC_STEP, state enum {IDLE, REQ}.
- Sub-module rr_arbiter (NTHREADS-wide request mask, last-grant pointer in, one-hot/index grant out, combinational).
- PC array, buffer, FSM and squash flag in fetch_sched.

## Test plan
- Reset, thread_en=4'b1111, f_ack one cycle after each request, ir_ready=1 -> f_thread sequence 0,1,2,3,0; f_addr 0,0,0,0,4.
- thread_en=4'b0101 -> only threads 0,2 alternate; thread_en=0 -> f_enable stays 0.
- ir_ready=0 after first word (data 32'hDEAD_BEEF) -> ir held stable, no new f_enable until ir_ready=1.
- Thread 1 REQ outstanding, br_valid thread 1 target 32'h100 -> acked word dropped, next thread-1 fetch at 32'h100.
- br_valid and f_ack same cycle, same thread -> ir_valid stays 0, pc=target; buffered word of br_thread cleared.
- Assert rst_n=0 during REQ -> all outputs reset values immediately, no ir_valid from late f_ack.
